// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: operation encodings and the
// controller state type.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_OP_SRL = 2'b00,
        SHIFT_OP_SRA = 2'b01,
        SHIFT_OP_SLL = 2'b10,
        SHIFT_OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bundle for the two-requester shift arbiter.
// master = request producer and result consumer; slave = the arbiter.
interface shift_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic [1:0]       req1_op;

    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [WIDTH-1:0] res_data;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_op,
        output req1_valid, req1_data, req1_amt, req1_op,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_data
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_op,
        input  req1_valid, req1_data, req1_amt, req1_op,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_data
    );
endinterface

// File: rtl/shift_unit.sv
// Combinational shifter shared by both requesters.
// Optional macro SHIFT_ARBITER_ROTATE_EN enables rotate-right for op 11.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);
    logic [31:0]      w_amt32;
    logic             w_big;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_ror;

    assign w_amt32 = 32'(amt);
    assign w_big   = (w_amt32 >= 32'(WIDTH));

    // Out-of-range amounts are forced explicitly rather than relying on
    // shift-operator overflow semantics.
    assign w_srl = w_big ? '0 : (data >> amt);
    assign w_sra = w_big ? {WIDTH{data[WIDTH-1]}} : WIDTH'($signed(data) >>> amt);
    assign w_sll = w_big ? '0 : (data << amt);

`ifdef SHIFT_ARBITER_ROTATE_EN
    logic [31:0]        w_rot_amt;
    logic [2*WIDTH-1:0] w_dbl;
    assign w_rot_amt = w_amt32 % 32'(WIDTH);
    assign w_dbl     = {data, data} >> w_rot_amt;
    assign w_ror     = w_dbl[WIDTH-1:0];
`else
    assign w_ror = w_srl;
`endif

    always_comb begin
        result = w_srl;
        case (shift_op_e'(op))
            SHIFT_OP_SRL: result = w_srl;
            SHIFT_OP_SRA: result = w_sra;
            SHIFT_OP_SLL: result = w_sll;
            SHIFT_OP_ROR: result = w_ror;
            default:      result = w_srl;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared shifter with a
// single result register. Optional macro: SHIFT_ARBITER_ROTATE_EN (see shift_unit).
//
// state | meaning
// IDLE  | result register empty; a valid request is granted immediately
// HOLD  | result register full; refill allowed only in a cycle with res_ready
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    shift_arbiter_if.slave  bus
);
    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_last;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_id;

    logic             w_any;
    logic             w_can_grant;
    logic             w_grant;
    logic             w_sel;
    logic [WIDTH-1:0] w_data;
    logic [AMT_W-1:0] w_amt;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_result;

    always_comb begin
        w_sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_sel = ~r_last;
        end else if (!bus.req0_valid) begin
            w_sel = 1'b1;
        end
    end

    // Gating with reset keeps ready low while reset is held, even in IDLE.
    assign w_any       = bus.req0_valid | bus.req1_valid;
    assign w_can_grant = (r_state == IDLE) | bus.res_ready;
    assign w_grant     = reset & w_can_grant & w_any;

    assign w_data = w_sel ? bus.req1_data : bus.req0_data;
    assign w_amt  = w_sel ? bus.req1_amt  : bus.req0_amt;
    assign w_op   = w_sel ? bus.req1_op   : bus.req0_op;

    shift_unit #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_shift (
        .data   (w_data),
        .amt    (w_amt),
        .op     (w_op),
        .result (w_result)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_nxt = HOLD;
            HOLD:    if (bus.res_ready && !w_grant) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_res_data <= '0;
            r_res_id   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_res_data <= w_result;
                r_res_id   <= w_sel;
                r_last     <= w_sel;
            end
        end
    end

    assign bus.req0_ready = w_grant & ~w_sel & bus.req0_valid;
    assign bus.req1_ready = w_grant &  w_sel & bus.req1_valid;
    assign bus.res_valid  = (r_state == HOLD);
    assign bus.res_id     = r_res_id;
    assign bus.res_data   = r_res_data;
endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed cases plus randomized
// traffic against a behavioural reference model.
module tb_shift_arbiter;
    localparam int W  = 4;
    localparam int AW = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    // reference model state
    bit             m_hold;
    bit             m_last;
    logic [W-1:0]   m_data;
    bit             m_id;

    shift_arbiter_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    shift_arbiter #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(logic [W-1:0] d, int amt, logic [1:0] op);
        logic [W-1:0] r;
        int eff_op;
        eff_op = int'(op);
`ifndef SHIFT_ARBITER_ROTATE_EN
        if (eff_op == 3) eff_op = 0;
`endif
        r = '0;
        case (eff_op)
            0: if (amt < W) r = W'(int'(d) / (1 << amt));
            1: for (int i = 0; i < W; i++) r[i] = (i + amt < W) ? d[i + amt] : d[W-1];
            2: if (amt < W) r = W'(int'(d) * (1 << amt));
            default: for (int i = 0; i < W; i++) r[i] = d[(i + amt) % W];
        endcase
        return r;
    endfunction

    // One clock: predict grant from the inputs, check readies before the edge,
    // then check the result register after it.
    task automatic step();
        bit can, v0, v1, win, g;
        @(negedge clk);
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        can = !m_hold || bus.res_ready;
        win = (v0 && v1) ? !m_last : !v0;
        g   = reset && can && (v0 || v1);
        check("req0_ready", 32'(bus.req0_ready), 32'(g && !win));
        check("req1_ready", 32'(bus.req1_ready), 32'(g && win));
        if (g) begin
            m_hold = 1'b1;
            m_id   = win;
            m_last = win;
            m_data = win ? ref_shift(bus.req1_data, int'(bus.req1_amt), bus.req1_op)
                         : ref_shift(bus.req0_data, int'(bus.req0_amt), bus.req0_op);
        end else if (m_hold && bus.res_ready) begin
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
        check("res_valid", 32'(bus.res_valid), 32'(m_hold));
        if (m_hold) begin
            check("res_data", 32'(bus.res_data), 32'(m_data));
            check("res_id", 32'(bus.res_id), 32'(m_id));
        end
    endtask

    task automatic set_req(input int n, input bit v, input logic [W-1:0] d,
                           input logic [AW-1:0] a, input logic [1:0] op);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a; bus.req1_op = op;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        m_hold = 1'b0;
        m_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_id", 32'(bus.res_id), 32'd0);
        check("rst_data", 32'(bus.res_data), 32'd0);
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        reset = 1'b1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] d, input logic [AW-1:0] a,
                            input logic [1:0] op, input logic [W-1:0] expv);
        set_req(0, 1'b1, d, a, op);
        set_req(1, 1'b0, '0, '0, 2'b00);
        bus.res_ready = 1'b1;
        step();
        check(tag, 32'(bus.res_data), 32'(expv));
        check({tag, "_id"}, 32'(bus.res_id), 32'd0);
        set_req(0, 1'b0, '0, '0, 2'b00);
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_hold = 1'b0; m_last = 1'b1; m_data = '0; m_id = 1'b0;
        bus.res_ready = 1'b1;
        set_req(0, 1'b1, 4'b1000, 4'd1, 2'b01);
        set_req(1, 1'b1, 4'b0110, 4'd2, 2'b10);
        do_reset();
        set_req(0, 1'b0, '0, '0, 2'b00);
        set_req(1, 1'b0, '0, '0, 2'b00);
        step();

        directed("sra_1", 4'b1000, 4'd1, 2'b01, 4'b1100);
        directed("srl_1", 4'b1000, 4'd1, 2'b00, 4'b0100);
        directed("sra_9", 4'b1000, 4'd9, 2'b01, 4'b1111);
        directed("srl_9", 4'b1000, 4'd9, 2'b00, 4'b0000);
        directed("sll_2", 4'b0011, 4'd2, 2'b10, 4'b1100);
        directed("sll_4", 4'b0011, 4'd4, 2'b10, 4'b0000);
`ifdef SHIFT_ARBITER_ROTATE_EN
        directed("ror_5", 4'b0001, 4'd5, 2'b11, 4'b1000);
`else
        directed("ror_5", 4'b0001, 4'd5, 2'b11, 4'b0000);
`endif

        // alternating grants from reset release
        set_req(0, 1'b1, 4'b1010, 4'd1, 2'b00);
        set_req(1, 1'b1, 4'b0101, 4'd1, 2'b10);
        bus.res_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_id", 32'(bus.res_id), 32'(k % 2));
        end

        // stall with both valid, then drain-and-refill
        bus.res_ready = 1'b0;
        repeat (3) step();
        bus.res_ready = 1'b1;
        step();
        check("refill_id", 32'(bus.res_id), 32'd0);

        // asynchronous reset while holding a result
        bus.res_ready = 1'b0;
        step();
        check("pre_rst_hold", 32'(bus.res_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_valid", 32'(bus.res_valid), 32'd0);
        check("async_ready0", 32'(bus.req0_ready), 32'd0);
        m_hold = 1'b0;
        m_last = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.res_ready = 1'b1;
        step();
        check("post_rst_id", 32'(bus.res_id), 32'd0);
        step();
        check("post_rst_id2", 32'(bus.res_id), 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_req(0, 1'($urandom_range(0, 1)), W'($urandom), AW'($urandom), 2'($urandom));
            set_req(1, 1'($urandom_range(0, 1)), W'($urandom), AW'($urandom), 2'($urandom));
            bus.res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
